// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetching instruction fetch front end with a DEPTH-entry queue
module fetch_queue #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                INST_BYTES = 4
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    output logic                      mem_valid,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_result,
    input  logic                      mem_ready,
    output logic                      inst_valid,
    output logic [ADDR_W-1:0]         inst_addr,
    output logic [DATA_W-1:0]         inst_result,
    input  logic                      dc_ok,
    input  logic [ADDR_W-1:0]         dc_next_pc,
    input  logic                      rob_clear,
    input  logic [ADDR_W-1:0]         rob_next_pc,
    output logic [$clog2(DEPTH):0]    q_count
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(INST_BYTES);

    // FS_DROP: a request is still outstanding but its data belongs to a
    // path that has since been flushed, so the response must be thrown away.
    typedef enum logic [1:0] {
        FS_IDLE,
        FS_BUSY,
        FS_DROP
    } fetch_state_t;

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;
    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];

    logic              head_valid;
    logic [ADDR_W-1:0] seq_pc;
    logic              pop_req;
    logic              redirect;
    logic              flush;
    logic [ADDR_W-1:0] flush_pc;
    logic              push;
    logic              pop;
    logic              issue;

    // The head is read straight out of the registered queue, so a pushed word
    // only becomes visible the cycle after its response.
    assign head_valid  = (count_q != '0);
    assign inst_valid  = head_valid;
    assign inst_addr   = q_addr[head_q];
    assign inst_result = q_data[head_q];
    assign mem_valid   = (state_q != FS_IDLE);
    assign mem_addr    = req_addr_q;
    assign q_count     = count_q;
    assign seq_pc      = q_addr[head_q] + STEP;

    // Decode this cycle's flush / push / pop / issue and the fetch FSM next state.
    always_comb begin
        pop_req  = 1'b0;
        redirect = 1'b0;
        flush    = 1'b0;
        flush_pc = dc_next_pc;
        push     = 1'b0;
        pop      = 1'b0;
        issue    = 1'b0;
        state_d  = state_q;

        pop_req  = dc_ok && head_valid;
        // rob_clear outranks the decoder, so its dc_ok is not looked at.
        redirect = !rob_clear && pop_req && (dc_next_pc != seq_pc);
        flush    = rob_clear || redirect;
        flush_pc = rob_clear ? rob_next_pc : dc_next_pc;
        // A response landing on a flush cycle, or while dropping, is never queued.
        push     = (state_q == FS_BUSY) && mem_ready && !flush;
        pop      = pop_req && !flush;
        // No issue on a flush cycle: the new fetch_pc is only valid next cycle.
        issue    = (state_q == FS_IDLE) && !flush && (count_q < DEPTH_C);

        case (state_q)
            FS_IDLE: begin
                if (issue) begin
                    state_d = FS_BUSY;
                end
            end
            FS_BUSY: begin
                if (mem_ready) begin
                    state_d = FS_IDLE;
                end else if (flush) begin
                    state_d = FS_DROP;
                end
            end
            FS_DROP: begin
                if (mem_ready) begin
                    state_d = FS_IDLE;
                end
            end
            default: state_d = FS_IDLE;
        endcase
    end

    // Fetch FSM state register; a global stall freezes it.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= FS_IDLE;
        end else if (rdy_in) begin
            state_q <= state_d;
        end
    end

    // Fetch PC, request address and queue storage/pointers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fetch_pc_q <= RESET_PC;
            req_addr_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_addr[i] <= '0;
                q_data[i] <= '0;
            end
        end else if (rdy_in) begin
            if (issue) begin
                req_addr_q <= fetch_pc_q;
            end
            if (flush) begin
                fetch_pc_q <= flush_pc;
                head_q     <= '0;
                tail_q     <= '0;
                count_q    <= '0;
            end else begin
                if (push) begin
                    q_addr[tail_q] <= fetch_pc_q;
                    q_data[tail_q] <= mem_result;
                    tail_q         <= tail_q + PTR_W'(1);
                    fetch_pc_q     <= fetch_pc_q + STEP;
                end
                if (pop) begin
                    head_q <= head_q + PTR_W'(1);
                end
                if (push && !pop) begin
                    count_q <= count_q + CNT_W'(1);
                end else if (pop && !push) begin
                    count_q <= count_q - CNT_W'(1);
                end
            end
        end
    end

endmodule
